// File: rtl/pong_match_sequencer.sv
// Match sequencer for two-player pong: serve / play / point / done phases, scores and ball gating.
// Optional `WIN_BY_TWO_EN: deuce rules (lead by two, scores run to 15, 15 wins outright).
module pong_match_sequencer #(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned POINT_HOLD  = 30
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_en,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] game_state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {IDLE, SERVE_WAIT, PLAY, POINT, DONE} state_t;

  localparam logic [7:0] SD  = 8'(SERVE_DELAY);
  localparam logic [7:0] PH  = 8'(POINT_HOLD);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
`ifdef WIN_BY_TWO_EN
  localparam logic [3:0] CAP = 4'd15;
`else
  localparam logic [3:0] CAP = WIN;
`endif

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       server_q, next_srv_q;   // 1 = P1 serves
  logic       ball_en_q, ball_load_q, serve_dir_q;
  logic [3:0] p1_q, p2_q;
  logic [1:0] gs_q, winner_q;

  logic [7:0] cnt_d;
  logic [3:0] p1_d, p2_d;
  logic       p1_wins, p2_wins;

  assign cnt_d = cnt_q - 8'd1;
  assign p1_d  = (p1_q >= CAP) ? CAP : p1_q + 4'd1;
  assign p2_d  = (p2_q >= CAP) ? CAP : p2_q + 4'd1;

`ifdef WIN_BY_TWO_EN
  assign p1_wins = (p1_q == 4'd15) || ((p1_q >= WIN) && ({1'b0, p1_q} >= {1'b0, p2_q} + 5'd2));
  assign p2_wins = (p2_q == 4'd15) || ((p2_q >= WIN) && ({1'b0, p2_q} >= {1'b0, p1_q} + 5'd2));
`else
  assign p1_wins = (p1_q == WIN);
  assign p2_wins = (p2_q == WIN);
`endif

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      server_q    <= 1'b1;
      next_srv_q  <= 1'b1;
      ball_en_q   <= 1'b0;
      ball_load_q <= 1'b0;
      serve_dir_q <= 1'b1;
      p1_q        <= '0;
      p2_q        <= '0;
      gs_q        <= 2'b00;
      winner_q    <= 2'b00;
    end else begin
      ball_load_q <= 1'b0;
      if (!start && (state_q inside {SERVE_WAIT, PLAY, POINT})) begin
        state_q   <= IDLE;
        ball_en_q <= 1'b0;
        p1_q      <= '0;
        p2_q      <= '0;
        gs_q      <= 2'b00;
        winner_q  <= 2'b00;
      end else begin
        case (state_q)
          IDLE: begin
            p1_q      <= '0;
            p2_q      <= '0;
            winner_q  <= 2'b00;
            ball_en_q <= 1'b0;
            if (start) begin
              state_q     <= SERVE_WAIT;
              server_q    <= 1'b1;
              serve_dir_q <= 1'b1;
              ball_load_q <= 1'b1;
              cnt_q       <= SD;
              gs_q        <= 2'b01;
            end
          end
          SERVE_WAIT: if (frame_tick) begin
            cnt_q <= cnt_d;
            if (cnt_q == 8'd1) begin
              state_q   <= PLAY;
              ball_en_q <= 1'b1;
            end
          end
          PLAY: if (miss_left || miss_right) begin
            state_q   <= POINT;
            ball_en_q <= 1'b0;
            cnt_q     <= PH;
            // The player who conceded serves next; a double miss replays the same serve.
            if (miss_left && !miss_right) begin
              p2_q       <= p2_d;
              next_srv_q <= 1'b1;
            end else if (miss_right && !miss_left) begin
              p1_q       <= p1_d;
              next_srv_q <= 1'b0;
            end else begin
              next_srv_q <= server_q;
            end
          end
          POINT: if (frame_tick) begin
            cnt_q <= cnt_d;
            if (cnt_q == 8'd1) begin
              if (p1_wins || p2_wins) begin
                state_q  <= DONE;
                gs_q     <= 2'b11;
                winner_q <= p1_wins ? 2'b01 : 2'b10;
              end else begin
                state_q     <= SERVE_WAIT;
                server_q    <= next_srv_q;
                serve_dir_q <= next_srv_q;
                gs_q        <= next_srv_q ? 2'b01 : 2'b10;
                ball_load_q <= 1'b1;
                cnt_q       <= SD;
              end
            end
          end
          DONE: begin
            ball_en_q <= 1'b0;
            if (!start) begin
              state_q  <= IDLE;
              p1_q     <= '0;
              p2_q     <= '0;
              winner_q <= 2'b00;
              gs_q     <= 2'b00;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ball_en    = ball_en_q;
  assign ball_load  = ball_load_q;
  assign serve_dir  = serve_dir_q;
  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign game_state = gs_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Bench for pong_match_sequencer: directed match scenarios plus random play against a phase-level model.
module tb_pong_match_sequencer;
  localparam int WS = 10, SDL = 2, PHL = 3;

  logic board_clk = 1'b0, reset = 1'b1, start = 1'b0, frame_tick = 1'b0;
  logic miss_left = 1'b0, miss_right = 1'b0;
  logic ball_en, ball_load, serve_dir;
  logic [3:0] p1_score, p2_score;
  logic [1:0] game_state, winner;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  pong_match_sequencer #(.WIN_SCORE(WS), .SERVE_DELAY(SDL), .POINT_HOLD(PHL)) dut (
    .board_clk(board_clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .ball_en(ball_en), .ball_load(ball_load),
    .serve_dir(serve_dir), .p1_score(p1_score), .p2_score(p2_score),
    .game_state(game_state), .winner(winner));

  always #5 board_clk = ~board_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Phase-level model: which phase, frames left, scores, who serves.
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_DONE = 4;
  int m_ph, m_rem, m_p1, m_p2, m_win;
  bit m_srv, m_nsrv, m_dir, m_load;

  function automatic bit m_won(int a, int b);
`ifdef WIN_BY_TWO_EN
    return (a == 15) || (a >= WS && a - b >= 2);
`else
    return a == WS;
`endif
  endfunction

  function automatic int m_cap();
`ifdef WIN_BY_TWO_EN
    return 15;
`else
    return WS;
`endif
  endfunction

  always @(posedge board_clk or posedge reset) begin
    if (reset) begin
      m_ph = M_IDLE; m_rem = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
      m_srv = 1; m_nsrv = 1; m_dir = 1; m_load = 0;
    end else begin
      m_load = 0;
      if (!start && m_ph inside {M_SERVE, M_PLAY, M_POINT, M_DONE}) begin
        m_ph = M_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0;
      end else if (m_ph == M_IDLE) begin
        m_p1 = 0; m_p2 = 0; m_win = 0;
        if (start) begin
          m_ph = M_SERVE; m_srv = 1; m_dir = 1; m_rem = SDL; m_load = 1;
        end
      end else if (m_ph == M_SERVE) begin
        if (frame_tick) begin
          m_rem--;
          if (m_rem == 0) m_ph = M_PLAY;
        end
      end else if (m_ph == M_PLAY) begin
        if (miss_left || miss_right) begin
          m_ph = M_POINT; m_rem = PHL;
          if (miss_left && miss_right) m_nsrv = m_srv;
          else if (miss_left) begin m_p2 = (m_p2 + 1 > m_cap()) ? m_cap() : m_p2 + 1; m_nsrv = 1; end
          else begin m_p1 = (m_p1 + 1 > m_cap()) ? m_cap() : m_p1 + 1; m_nsrv = 0; end
        end
      end else if (m_ph == M_POINT) begin
        if (frame_tick) begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_won(m_p1, m_p2)) begin m_ph = M_DONE; m_win = 1; end
            else if (m_won(m_p2, m_p1)) begin m_ph = M_DONE; m_win = 2; end
            else begin m_ph = M_SERVE; m_srv = m_nsrv; m_dir = m_nsrv; m_rem = SDL; m_load = 1; end
          end
        end
      end
    end
  end

  always @(negedge board_clk) begin
    if (cmp_en && !reset) begin
      chk("m_ball_en", ball_en, m_ph == M_PLAY);
      chk("m_ball_load", ball_load, m_load);
      chk("m_serve_dir", serve_dir, m_dir);
      chk("m_p1", p1_score, m_p1);
      chk("m_p2", p2_score, m_p2);
      chk("m_state", game_state, m_ph == M_IDLE ? 0 : m_ph == M_DONE ? 3 : (m_srv ? 1 : 2));
      chk("m_winner", winner, m_win);
    end
  end

  task automatic step(input bit t, input bit l, input bit r);
    frame_tick = t; miss_left = l; miss_right = r;
    @(negedge board_clk);
    frame_tick = 0; miss_left = 0; miss_right = 0;
  endtask

  // From the first serve-wait cycle: release the ball, miss, then hold the point.
  task automatic point(input bit l, input bit r);
    for (int i = 0; i < SDL; i++) step(1, 0, 0);
    step(0, l, r);
    for (int i = 0; i < PHL; i++) step(1, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; start = 0;
    repeat (2) @(negedge board_clk);
    reset = 0;
  endtask

  initial begin
    repeat (2) @(negedge board_clk);
    chk("rst_ball_en", ball_en, 0); chk("rst_serve_dir", serve_dir, 1);
    chk("rst_state", game_state, 0); chk("rst_winner", winner, 0);
    reset = 0; cmp_en = 1;
    step(0, 0, 0);
    start = 1;
    step(0, 0, 0);
    chk("start_load", ball_load, 1); chk("start_state", game_state, 1); chk("start_dir", serve_dir, 1);
    step(1, 0, 0);
    chk("serve_load_drop", ball_load, 0); chk("serve_en_low", ball_en, 0);
    step(1, 0, 0);
    chk("release_en", ball_en, 1);
    step(0, 0, 1);
    chk("p1_point", p1_score, 1); chk("point_en", ball_en, 0);
    for (int i = 0; i < PHL; i++) step(1, 0, 0);
    chk("p2_serve_state", game_state, 2); chk("p2_serve_dir", serve_dir, 0); chk("p2_serve_load", ball_load, 1);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 1, 1);
    chk("both_p1", p1_score, 1); chk("both_p2", p2_score, 0);
    for (int i = 0; i < PHL; i++) step(1, 0, 0);
    chk("reserve_state", game_state, 2); chk("reserve_load", ball_load, 1);
    for (int n = 0; n < 10; n++) point(1, 0);
    chk("match_p2", p2_score, 10); chk("match_state", game_state, 3);
    chk("match_winner", winner, 2); chk("match_en", ball_en, 0);
    repeat (4) step(1, 0, 1);
    chk("done_hold", game_state, 3); chk("done_p1", p1_score, 1);
    start = 0;
    step(0, 0, 0);
    chk("idle_state", game_state, 0); chk("idle_p2", p2_score, 0);

    // Async reset mid-play at 3-5.
    start = 1; step(0, 0, 0);
    for (int n = 0; n < 3; n++) point(0, 1);
    for (int n = 0; n < 5; n++) point(1, 0);
    step(1, 0, 0); step(1, 0, 0);
    chk("pre_rst_p1", p1_score, 3); chk("pre_rst_p2", p2_score, 5); chk("pre_rst_en", ball_en, 1);
    #2 reset = 1;
    #1;
    chk("arst_en", ball_en, 0); chk("arst_p1", p1_score, 0); chk("arst_p2", p2_score, 0);
    chk("arst_state", game_state, 0); chk("arst_dir", serve_dir, 1);
    @(negedge board_clk); reset = 0;
    step(0, 0, 0);
    chk("restart_load", ball_load, 1);
    start = 0;
    step(1, 0, 0);
    chk("abort_state", game_state, 0); chk("abort_load", ball_load, 0);
    step(0, 0, 0);
    chk("abort_load2", ball_load, 0);

`ifdef WIN_BY_TWO_EN
    start = 1; step(0, 0, 0);
    for (int n = 0; n < 10; n++) begin point(0, 1); point(1, 0); end
    point(0, 1);
    chk("deuce_p1", p1_score, 11); chk("deuce_state", game_state, 2);
    point(0, 1);
    chk("deuce_win", winner, 1); chk("deuce_done", game_state, 3);
    start = 0; step(0, 0, 0);
`endif

    // Random play; the compare process checks every cycle.
    start = 1;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
